// File: rtl/spi_initiator.sv
// SPI mode-0 initiator: shifts a WIDTH-bit word out MSB-first on mosi and captures miso into rx_data.
// Define SPI_LOOPBACK_EN to sample the registered mosi instead of the miso pin (rx_data == tx_data).
module spi_initiator #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]   tx_sr_q;
    logic [WIDTH-1:0]   rx_sr_q;
    logic [WIDTH-1:0]   rx_data_q;
    logic               busy_q;
    logic               done_q;
    logic               sclk_q;
    logic               cs_n_q;
    logic               mosi_q;
    logic               sample_bit_s;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso_s;
    assign unused_miso_s = miso;
    assign sample_bit_s  = mosi_q;
`else
    assign sample_bit_s  = miso;
`endif

    // Transfer sequencer: every pin output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr_q   <= tx_data;
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        cs_n_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        mosi_q    <= tx_data[WIDTH-1];
                        sclk_q    <= 1'b0;
                        state_q   <= ST_LOW;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b1;
                        rx_sr_q   <= {rx_sr_q[WIDTH-2:0], sample_bit_s};
                        state_q   <= ST_HIGH;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        sclk_q    <= 1'b0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q <= ST_TAIL;
                        end else begin
                            // tx_sr_q[WIDTH-1] is the bit just sent; the next one sits below it.
                            tx_sr_q   <= {tx_sr_q[WIDTH-2:0], 1'b0};
                            mosi_q    <= tx_sr_q[WIDTH-2];
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            state_q   <= ST_LOW;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_q <= '0;
                        cs_n_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        rx_data_q <= rx_sr_q;
                        mosi_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    busy_q    <= 1'b0;
                    sclk_q    <= 1'b0;
                    cs_n_q    <= 1'b1;
                    mosi_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_initiator.sv
// Self-checking bench: two initiators (CLK_DIV=2 and CLK_DIV=1) driven by a table, random words and corner sequences.
module tb_spi_initiator;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start_a, start_b, miso_a, miso_b, sel;
    logic [W-1:0] tx_data;
    logic         busy_a, done_a, sclk_a, cs_n_a, mosi_a;
    logic         busy_b, done_b, sclk_b, cs_n_b, mosi_b;
    logic [W-1:0] rx_a, rx_b;

    spi_initiator #(.WIDTH(W), .CLK_DIV(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_data),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a),
        .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_initiator #(.WIDTH(W), .CLK_DIV(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_data),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b),
        .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    wire         c_busy = sel ? busy_b : busy_a;
    wire         c_done = sel ? done_b : done_a;
    wire         c_sclk = sel ? sclk_b : sclk_a;
    wire         c_cs_n = sel ? cs_n_b : cs_n_a;
    wire         c_mosi = sel ? mosi_b : mosi_a;
    wire [W-1:0] c_rx   = sel ? rx_b   : rx_a;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: what the link should deliver, from the protocol rules alone.
    function automatic logic [W-1:0] model_rx(input logic [W-1:0] tx, input logic [W-1:0] resp);
`ifdef SPI_LOOPBACK_EN
        return tx;
`else
        return resp;
`endif
    endfunction

    function automatic int model_busy(input int div);
        return W * 2 * div + div;
    endfunction

    task automatic set_miso(input logic b);
        if (sel) miso_b = b;
        else     miso_a = b;
    endtask

    task automatic set_start(input logic b);
        if (sel) start_b = b;
        else     start_a = b;
    endtask

    // One transfer on the selected instance, with a mode-0 responder returning resp.
    task automatic xfer(input logic s, input logic [W-1:0] tx, input logic [W-1:0] resp,
                        input int exp_busy, input logic [W-1:0] exp_rx);
        int       div;
        int       busy_cnt, rises, cyc, last_rise, bad_period, overlap;
        logic [W-1:0] mosi_w;
        logic     prev_sclk;
        bit       finished;
        div = s ? 1 : 2;
        busy_cnt = 0; rises = 0; last_rise = -1; bad_period = 0; overlap = 0;
        mosi_w = '0; prev_sclk = 1'b0; finished = 1'b0;
        @(negedge clk);
        sel = s;
        tx_data = tx;
        set_miso(resp[W-1]);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        tx_data = ~tx;
        chk("accept_cs_n", {31'd0, c_cs_n}, 32'd0);
        cyc = 1;
        while (cyc <= 200) begin
            if (!c_busy) begin
                finished = 1'b1;
                break;
            end
            busy_cnt++;
            if (c_done) overlap++;
            if (c_sclk && !prev_sclk) begin
                if (last_rise >= 0 && (cyc - last_rise) != 2 * div) bad_period++;
                last_rise = cyc;
                mosi_w = {mosi_w[W-2:0], c_mosi};
                rises++;
            end
            if (!c_sclk && rises < W) set_miso(resp[W-1-rises]);
            prev_sclk = c_sclk;
            @(negedge clk);
            cyc++;
        end
        chk("xfer_finished", {31'd0, finished}, 32'd1);
        chk("done_pulse", {31'd0, c_done}, 32'd1);
        chk("cs_n_end", {31'd0, c_cs_n}, 32'd1);
        chk("mosi_end", {31'd0, c_mosi}, 32'd0);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("sclk_rises", rises, W);
        chk("mosi_bits", {24'd0, mosi_w}, {24'd0, tx});
        chk("sclk_period", bad_period, 0);
        chk("done_busy_overlap", overlap, 0);
        chk("rx_data", {24'd0, c_rx}, {24'd0, exp_rx});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, c_done}, 32'd0);
    endtask

    typedef struct {
        logic         s;
        logic [W-1:0] tx;
        logic [W-1:0] resp;
        logic [W-1:0] exp_rx;
        int           exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int first_done, busy_before, dones, waited;
        logic s;
        logic [W-1:0] tx, resp;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        miso_a = 1'b0; miso_b = 1'b0; sel = 1'b0; tx_data = '0;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        chk("rst_sclk",  {30'd0, sclk_a, sclk_b}, 32'd0);
        chk("rst_cs_n",  {30'd0, cs_n_a, cs_n_b}, 32'd3);
        chk("rst_mosi",  {30'd0, mosi_a, mosi_b}, 32'd0);
        chk("rst_busy",  {30'd0, busy_a, busy_b}, 32'd0);
        chk("rst_done",  {30'd0, done_a, done_b}, 32'd0);
        chk("rst_rx",    {16'd0, rx_a, rx_b}, 32'd0);
        rst_n = 1'b1;

        // Reset during a transfer aborts it without a done pulse.
        @(negedge clk);
        sel = 1'b0; tx_data = 8'h81; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy_a}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_cs_n", {31'd0, cs_n_a}, 32'd1);
        chk("midrst_sclk", {31'd0, sclk_a}, 32'd0);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_mosi", {31'd0, mosi_a}, 32'd0);
        dones = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        chk("midrst_no_done", dones, 0);
        chk("midrst_rx", {24'd0, rx_a}, 32'd0);

        // Vector table: instance select, word, responder word, expected rx and busy length.
        vecs[0] = '{1'b0, 8'hA5, 8'h3C, model_rx(8'hA5, 8'h3C), 34};
        vecs[1] = '{1'b1, 8'h5A, 8'hFF, model_rx(8'h5A, 8'hFF), 17};
        vecs[2] = '{1'b0, 8'h00, 8'hFF, model_rx(8'h00, 8'hFF), 34};
        vecs[3] = '{1'b0, 8'hFF, 8'h00, model_rx(8'hFF, 8'h00), 34};
        vecs[4] = '{1'b1, 8'h81, 8'h7E, model_rx(8'h81, 8'h7E), 17};
        vecs[5] = '{1'b0, 8'hC3, 8'h00, model_rx(8'hC3, 8'h00), 34};
        for (int i = 0; i < 6; i++)
            xfer(vecs[i].s, vecs[i].tx, vecs[i].resp, vecs[i].exp_busy, vecs[i].exp_rx);

        for (int i = 0; i < 20; i++) begin
            s    = 1'($urandom_range(0, 1));
            tx   = 8'($urandom);
            resp = 8'($urandom);
            xfer(s, tx, resp, model_busy(s ? 1 : 2), model_rx(tx, resp));
        end

        // start held high: back-to-back with a one-cycle cs_n gap, mid-transfer start ignored.
        @(negedge clk);
        sel = 1'b0; miso_a = 1'b0; tx_data = 8'hFF; start_a = 1'b1;
        first_done = -1; busy_before = 0; dones = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (done_a) dones++;
            if (first_done < 0) begin
                if (busy_a) busy_before++;
                if (done_a) begin
                    first_done = i;
                    chk("b2b_gap_cs_n", {31'd0, cs_n_a}, 32'd1);
                    chk("b2b_done_busy", {31'd0, busy_a}, 32'd0);
                    chk("b2b_rx1", {24'd0, rx_a}, {24'd0, model_rx(8'hFF, 8'h00)});
                end
            end else if (i == first_done + 1) begin
                chk("b2b_reassert_cs_n", {31'd0, cs_n_a}, 32'd0);
                chk("b2b_reaccept_busy", {31'd0, busy_a}, 32'd1);
            end
        end
        start_a = 1'b0;
        chk("b2b_first_done_cycle", first_done, 35);
        chk("b2b_busy_len", busy_before, 34);
        chk("b2b_dones_in_window", dones, 1);
        waited = 0;
        while (!done_a && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("b2b_second_done", {31'd0, done_a}, 32'd1);
        chk("b2b_rx2", {24'd0, rx_a}, {24'd0, model_rx(8'hFF, 8'h00)});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
